// File: rtl/sync_fifo_rv_if.sv
// Handshake bundle for sync_fifo_rv: valid-only write stream, ready/valid
// read side, fill level and overflow status.
interface sync_fifo_rv_if #(
   parameter int WIDTH      = 2,
   parameter int DEPTH_LOG2 = 4
);
   logic [WIDTH-1:0]    DIN;
   logic                DIN_DV;
   logic [WIDTH-1:0]    DOUT;
   logic                DOUT_DV;
   logic                DOUT_RDY;
   logic [DEPTH_LOG2:0] COUNT;
   logic                FULL;
   logic                EMPTY;
   logic                OVERFLOW;
   logic                OVF_CLR;
   logic [7:0]          DROP_CNT;

   // Producer/consumer side.
   modport master (
      output DIN, DIN_DV, DOUT_RDY, OVF_CLR,
      input  DOUT, DOUT_DV, COUNT, FULL, EMPTY, OVERFLOW, DROP_CNT
   );

   // FIFO side.
   modport slave (
      input  DIN, DIN_DV, DOUT_RDY, OVF_CLR,
      output DOUT, DOUT_DV, COUNT, FULL, EMPTY, OVERFLOW, DROP_CNT
   );
endinterface

// File: rtl/sync_fifo_rv.sv
// Single-clock first-word-fall-through FIFO: valid-only input stream,
// ready/valid output, fill level, sticky overflow and saturating drop count.
module sync_fifo_rv #(
   parameter int WIDTH      = 2,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic          CLK,
   input  logic          RST,
   sync_fifo_rv_if.slave bus
);
   localparam int                    DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
   localparam logic [7:0]            DROP_ONE = 8'h01;
   localparam logic [7:0]            DROP_MAX = 8'hFF;

   logic [WIDTH-1:0]      mem_reg [DEPTH];
   logic [DEPTH_LOG2-1:0] wp_reg;
   logic [DEPTH_LOG2-1:0] rp_reg;
   logic [DEPTH_LOG2:0]   count_reg;
   logic [DEPTH_LOG2:0]   count_next;
   logic                  overflow_reg;
   logic                  overflow_next;
   logic [7:0]            drop_cnt_reg;
   logic [7:0]            drop_cnt_next;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic drop;

   assign full  = (count_reg == CNT_FULL);
   assign empty = (count_reg == '0);
   assign pop   = !empty && bus.DOUT_RDY;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push  = bus.DIN_DV && (!full || pop);
   assign drop  = bus.DIN_DV && full && !pop;

   always_comb begin
      count_next = count_reg;
      if (push && !pop) begin
         count_next = count_reg + CNT_ONE;
      end else if (pop && !push) begin
         count_next = count_reg - CNT_ONE;
      end
   end

   // A drop coinciding with a clear restarts the count at one.
   always_comb begin
      overflow_next = overflow_reg;
      drop_cnt_next = drop_cnt_reg;
      if (drop) begin
         overflow_next = 1'b1;
         if (bus.OVF_CLR) begin
            drop_cnt_next = DROP_ONE;
         end else if (drop_cnt_reg != DROP_MAX) begin
            drop_cnt_next = drop_cnt_reg + DROP_ONE;
         end
      end else if (bus.OVF_CLR) begin
         overflow_next = 1'b0;
         drop_cnt_next = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wp_reg       <= '0;
         rp_reg       <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         if (push) begin
            wp_reg <= wp_reg + PTR_ONE;
         end
         if (pop) begin
            rp_reg <= rp_reg + PTR_ONE;
         end
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   // Storage is left uninitialised by reset; only the pointers are cleared.
   always_ff @(posedge CLK) begin
      if (push && !RST) begin
         mem_reg[wp_reg] <= bus.DIN;
      end
   end

   assign bus.DOUT     = empty ? '0 : mem_reg[rp_reg];
   assign bus.DOUT_DV  = !empty;
   assign bus.COUNT    = count_reg;
   assign bus.FULL     = full;
   assign bus.EMPTY    = empty;
   assign bus.OVERFLOW = overflow_reg;
   assign bus.DROP_CNT = drop_cnt_reg;
endmodule
